// File: rtl/ehgu_fifo_ctrl_sc.sv
// Single-clock FIFO controller: pointers, occupancy, flags and push/pop handshake for an external SDP RAM.
// Optional sticky overflow/underflow error outputs are enabled by defining EHGU_FIFO_ERR_EN.
module ehgu_fifo_ctrl_sc #(
    parameter int AWIDTH    = 8,
    parameter int DEPTH     = 128,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              clr,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic              pop_req,
    output logic              wenable,
    output logic [AWIDTH-1:0] waddr,
    output logic              renable,
    output logic [AWIDTH-1:0] raddr,
    output logic              dout_valid,
    output logic [AWIDTH:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty
`ifdef EHGU_FIFO_ERR_EN
    ,
    output logic              overflow_err,
    output logic              underflow_err
`endif
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH-1:0] ADDR_ONE  = AWIDTH'(1);
    localparam logic [AWIDTH:0]   DEPTH_C   = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0]   AF_C      = (AWIDTH + 1)'(AF_THRESH);
    localparam logic [AWIDTH:0]   AE_C      = (AWIDTH + 1)'(AE_THRESH);
    localparam logic [AWIDTH:0]   CNT_ONE   = (AWIDTH + 1)'(1);

    logic [AWIDTH-1:0] waddr_q, waddr_d;
    logic [AWIDTH-1:0] raddr_q, raddr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic [RD_LAT-1:0] pipe_q,  pipe_d;

    // Flags come only from registered count so they never glitch on inputs.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    assign push_ready = en & ~full;
    assign wenable    = push_valid & push_ready & ~clr;
    assign renable    = pop_req & en & ~empty & ~clr;

    assign waddr      = waddr_q;
    assign raddr      = raddr_q;
    assign count      = count_q;
    assign dout_valid = pipe_q[RD_LAT-1];

    always_comb begin
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        count_d = count_q;
        pipe_d  = pipe_q;
        if (clr) begin
            waddr_d = '0;
            raddr_d = '0;
            count_d = '0;
            pipe_d  = '0;
        end else begin
            // Wrap by compare so non-power-of-2 depths work.
            if (wenable) begin
                waddr_d = (waddr_q == LAST_ADDR) ? '0 : waddr_q + ADDR_ONE;
            end
            if (renable) begin
                raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + ADDR_ONE;
            end
            case ({wenable, renable})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            pipe_d[0] = renable;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            waddr_q <= '0;
            raddr_q <= '0;
            count_q <= '0;
            pipe_q  <= '0;
        end else begin
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            count_q <= count_d;
            pipe_q  <= pipe_d;
        end
    end

`ifdef EHGU_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky until clr; the offending request itself is still dropped.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_valid & en & full) begin
                overflow_d = 1'b1;
            end
            if (pop_req & en & empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;
`endif

endmodule

// File: tb/tb_ehgu_fifo_ctrl_sc.sv
// Directed table-driven bench for ehgu_fifo_ctrl_sc (DEPTH=5, AF=4, AE=1, RD_LAT=2).
// Error-output checks are included when EHGU_FIFO_ERR_EN is defined.
module tb_ehgu_fifo_ctrl_sc;

    localparam int AW = 3;

    logic          clk;
    logic          rstn;
    logic          en;
    logic          clr;
    logic          push_valid;
    logic          push_ready;
    logic          pop_req;
    logic          wenable;
    logic [AW-1:0] waddr;
    logic          renable;
    logic [AW-1:0] raddr;
    logic          dout_valid;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
`ifdef EHGU_FIFO_ERR_EN
    logic          overflow_err;
    logic          underflow_err;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    ehgu_fifo_ctrl_sc #(
        .AWIDTH(AW), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .RD_LAT(2)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr),
        .push_valid(push_valid), .push_ready(push_ready), .pop_req(pop_req),
        .wenable(wenable), .waddr(waddr), .renable(renable), .raddr(raddr),
        .dout_valid(dout_valid), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef EHGU_FIFO_ERR_EN
        , .overflow_err(overflow_err), .underflow_err(underflow_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, clr, pv, pr;
        logic       we, re;
        int         wa, ra, cnt;
        logic       full, empty, af, ae, prdy, dv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic e, logic c, logic pv, logic pr,
                                logic we, logic re, int wa, int ra, int cnt,
                                logic f, logic em, logic af, logic ae,
                                logic prdy, logic dv);
        vec_t v;
        v.en = e; v.clr = c; v.pv = pv; v.pr = pr;
        v.we = we; v.re = re; v.wa = wa; v.ra = ra; v.cnt = cnt;
        v.full = f; v.empty = em; v.af = af; v.ae = ae; v.prdy = prdy; v.dv = dv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        en = v.en; clr = v.clr; push_valid = v.pv; pop_req = v.pr;
        #2;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        chk({p, ".wenable"},      32'(wenable),      32'(v.we));
        chk({p, ".renable"},      32'(renable),      32'(v.re));
        chk({p, ".waddr"},        32'(waddr),        32'(v.wa));
        chk({p, ".raddr"},        32'(raddr),        32'(v.ra));
        chk({p, ".count"},        32'(count),        32'(v.cnt));
        chk({p, ".full"},         32'(full),         32'(v.full));
        chk({p, ".empty"},        32'(empty),        32'(v.empty));
        chk({p, ".almost_full"},  32'(almost_full),  32'(v.af));
        chk({p, ".almost_empty"}, 32'(almost_empty), 32'(v.ae));
        chk({p, ".push_ready"},   32'(push_ready),   32'(v.prdy));
        chk({p, ".dout_valid"},   32'(dout_valid),   32'(v.dv));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            push_valid = 1'b0; pop_req = 1'b0; clr = 1'b0; en = 1'b1;
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; clr = 1'b0; push_valid = 1'b0; pop_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.count", 32'(count), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.dout_valid", 32'(dout_valid), 0);
        rstn = 1'b1;
        en   = 1'b1;

        // Fill to full: six pushes, sixth blocked.
        vecs.push_back(mk(1,0,1,0, 1,0,0,0,0, 0,1,0,1,1,0));
        vecs.push_back(mk(1,0,1,0, 1,0,1,0,1, 0,0,0,1,1,0));
        vecs.push_back(mk(1,0,1,0, 1,0,2,0,2, 0,0,0,0,1,0));
        vecs.push_back(mk(1,0,1,0, 1,0,3,0,3, 0,0,0,0,1,0));
        vecs.push_back(mk(1,0,1,0, 1,0,4,0,4, 0,0,1,0,1,0));
        vecs.push_back(mk(1,0,1,0, 0,0,0,0,5, 1,0,1,0,0,0));
        // Drain with RD_LAT=2, sixth pop blocked on empty.
        vecs.push_back(mk(1,0,0,1, 0,1,0,0,5, 1,0,1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,1,0,1,4, 0,0,1,0,1,0));
        vecs.push_back(mk(1,0,0,1, 0,1,0,2,3, 0,0,0,0,1,1));
        vecs.push_back(mk(1,0,0,1, 0,1,0,3,2, 0,0,0,0,1,1));
        vecs.push_back(mk(1,0,0,1, 0,1,0,4,1, 0,0,0,1,1,1));
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0, 0,1,0,1,1,1));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,0, 0,1,0,1,1,1));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,0, 0,1,0,1,1,0));
        // Push+pop on empty: no bypass.
        vecs.push_back(mk(1,0,1,1, 1,0,0,0,0, 0,1,0,1,1,0));
        vecs.push_back(mk(1,0,1,0, 1,0,1,0,1, 0,0,0,1,1,0));
        vecs.push_back(mk(1,0,1,0, 1,0,2,0,2, 0,0,0,0,1,0));
        // Ten simultaneous push/pop cycles at count 3; pointers wrap mod 5.
        for (int k = 0; k < 10; k++) begin
            vecs.push_back(mk(1,0,1,1, 1,1,(3+k)%5,k%5,3, 0,0,0,0,1,(k>=2)));
        end
        vecs.push_back(mk(1,0,1,0, 1,0,3,0,3, 0,0,0,0,1,1));
        // clr at count 4 with push and pop requested.
        vecs.push_back(mk(1,1,1,1, 0,0,4,0,4, 0,0,1,0,1,1));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,0, 0,1,0,1,1,0));
        // clr while a read is in flight drops its dout_valid.
        vecs.push_back(mk(1,0,1,0, 1,0,0,0,0, 0,1,0,1,1,0));
        vecs.push_back(mk(1,0,0,1, 0,1,1,0,1, 0,0,0,1,1,0));
        vecs.push_back(mk(1,1,0,1, 0,0,1,1,0, 0,1,0,1,1,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,0, 0,1,0,1,1,0));
        // en=0 holds state while the read pipe still drains.
        vecs.push_back(mk(0,0,1,1, 0,0,0,0,0, 0,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0, 1,0,0,0,0, 0,1,0,1,1,0));
        vecs.push_back(mk(0,0,0,1, 0,0,1,0,1, 0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,1, 0,1,1,0,1, 0,0,0,1,1,0));
        vecs.push_back(mk(1,0,0,0, 0,0,1,1,0, 0,1,0,1,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,1,1,0, 0,1,0,1,0,1));
        vecs.push_back(mk(1,0,0,0, 0,0,1,1,0, 0,1,0,1,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // Asynchronous reset mid-operation.
        @(negedge clk);
        en = 1'b1; push_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push_valid = 1'b0;
        #2;
        chk("mid.count_before", 32'(count), 2);
        rstn = 1'b0;
        #1;
        chk("mid.count_async", 32'(count), 0);
        chk("mid.waddr_async", 32'(waddr), 0);
        chk("mid.raddr_async", 32'(raddr), 0);
        chk("mid.empty_async", 32'(empty), 1);
        @(negedge clk);
        rstn = 1'b1;
        #2;
        chk("mid.push_ready", 32'(push_ready), 1);

`ifdef EHGU_FIFO_ERR_EN
        @(negedge clk);
        pop_req = 1'b1;
        #2;
        chk("err.renable_empty", 32'(renable), 0);
        idleCycles(1);
        #2;
        chk("err.underflow", 32'(underflow_err), 1);
        chk("err.overflow_0", 32'(overflow_err), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            push_valid = 1'b1;
        end
        idleCycles(2);
        #2;
        chk("err.count_full", 32'(count), 5);
        chk("err.overflow", 32'(overflow_err), 1);
        chk("err.underflow_sticky", 32'(underflow_err), 1);
        @(negedge clk);
        clr = 1'b1;
        idleCycles(1);
        #2;
        chk("err.overflow_clr", 32'(overflow_err), 0);
        chk("err.underflow_clr", 32'(underflow_err), 0);
        chk("err.count_clr", 32'(count), 0);
`endif

        idleCycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
